dmem_access_unit: RTL

- Data-memory responder at the memory end of the control unit's READ/WRITE/BUSYWAIT handshake, in the MEM stage of the RV32IM pipeline.
- Accepts one load or store request at a time and holds BUSYWAIT high for a programmable access latency.
- Performs byte, half or word access on an internal byte-addressed array and returns sign- or zero-extended load data.

---
 rtl/dmem_access_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory responder for the MEM stage READ/WRITE/BUSYWAIT handshake.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    input  logic [2:0]  LOADSIGNAL,
    input  logic [1:0]  STORESIGNAL,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int WORDS = DEPTH / 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = (AW > 2) ? AW - 2 : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] ADDR_MASK = 32'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  ld_q;
    logic [1:0]  st_q;
    logic        store_q;
    logic [31:0] rdata_q;

    logic [31:0] mem_q [WORDS];

    logic [31:0] byte_off;
    logic [31:0] word_sel;
    logic [WW-1:0] widx;
    logic [1:0]  lane;
    logic [31:0] word_rd;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_d;
    logic [3:0]  be_d;
    logic [31:0] wd_d;
    logic        finish;
    logic        skip;
    logic        mem_we;
    logic        unused_ok;

    assign byte_off = addr_q & ADDR_MASK;
    assign word_sel = byte_off >> 2;
    assign widx     = word_sel[WW-1:0];
    assign lane     = byte_off[1:0];
    assign word_rd  = mem_q[widx];
    assign half_v   = lane[1] ? word_rd[31:16] : word_rd[15:0];
    assign unused_ok = ^word_sel[31:WW];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_in;
    logic mis_req_q;
    logic mis_q;

    // Misalignment of the request currently on the inputs
    always_comb begin
        mis_in = 1'b0;
        if (WRITE) begin
            if (STORESIGNAL == 2'd2) mis_in = ADDRESS[0];
            if (STORESIGNAL == 2'd3) mis_in = |ADDRESS[1:0];
        end else begin
            if (LOADSIGNAL == 3'd2 || LOADSIGNAL == 3'd5) mis_in = ADDRESS[0];
            if (LOADSIGNAL == 3'd3) mis_in = |ADDRESS[1:0];
        end
    end

    assign skip       = mis_req_q;
    assign MISALIGNED = mis_q;
`else
    assign skip       = 1'b0;
    assign MISALIGNED = 1'b0;
`endif

    assign finish   = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign mem_we   = finish && store_q && !skip && !RESET;
    assign BUSYWAIT = ((state_q == IDLE) && (READ || WRITE)) ||
                      (state_q == ACCESS);
    assign READDATA = rdata_q;

    // Select the addressed byte lane of the stored word
    always_comb begin
        byte_v = word_rd[7:0];
        case (lane)
            2'd1:    byte_v = word_rd[15:8];
            2'd2:    byte_v = word_rd[23:16];
            2'd3:    byte_v = word_rd[31:24];
            default: byte_v = word_rd[7:0];
        endcase
    end

    // Extend the selected byte/half/word according to the load kind
    always_comb begin
        load_d = '0;
        case (ld_q)
            3'd1:    load_d = {{24{byte_v[7]}}, byte_v};
            3'd2:    load_d = {{16{half_v[15]}}, half_v};
            3'd3:    load_d = word_rd;
            3'd4:    load_d = {24'd0, byte_v};
            3'd5:    load_d = {16'd0, half_v};
            default: load_d = '0;
        endcase
    end

    // Byte enables and lane-replicated data for the store
    always_comb begin
        be_d = 4'b0000;
        wd_d = '0;
        case (st_q)
            2'd1: begin
                be_d = 4'b0001 << lane;
                wd_d = {4{wdata_q[7:0]}};
            end
            2'd2: begin
                be_d = lane[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{wdata_q[15:0]}};
            end
            2'd3: begin
                be_d = 4'b1111;
                wd_d = wdata_q;
            end
            default: begin
                be_d = 4'b0000;
                wd_d = '0;
            end
        endcase
    end

    // Memory array write on the completion edge; contents survive reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem_q[widx][8*i +: 8] <= wd_d[8*i +: 8];
            end
        end
    end

    // Handshake FSM: latch request, count latency, release for one cycle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            st_q    <= '0;
            store_q <= 1'b0;
            rdata_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_req_q <= 1'b0;
            mis_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (READ || WRITE) begin
                        addr_q  <= ADDRESS;
                        wdata_q <= WRITEDATA;
                        ld_q    <= LOADSIGNAL;
                        st_q    <= STORESIGNAL;
                        store_q <= WRITE;
                        cnt_q   <= CNT_INIT;
                        state_q <= ACCESS;
`ifdef DMEM_MISALIGN_TRAP_EN
                        mis_req_q <= mis_in;
                        mis_q     <= 1'b0;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (!store_q && !skip) rdata_q <= load_d;
`ifdef DMEM_MISALIGN_TRAP_EN
                        mis_q <= mis_req_q;
`endif
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
